// File: rtl/irq_arb_pkg.sv
// irq_arb_pkg: shared state encoding, config register map and cause base for the interrupt arbiter
package irq_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
  localparam logic [1:0] CFG_ENABLE   = 2'd0;
  localparam logic [1:0] CFG_EDGE_SEL = 2'd1;
  localparam logic [1:0] CFG_PENDING  = 2'd2;
  localparam logic [1:0] CFG_CLAIM    = 2'd3;
  localparam logic [31:0] IRQ_CAUSE_BASE = 32'h1000_0010;
endpackage

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: controller handshake and config bus between the arbiter (slave) and core side (master)
interface irq_arbiter_if #(
  parameter int N_SRC = 16,
  parameter int ID_W  = $clog2(N_SRC)
);
  logic            irq_ack_i;
  logic            irq_done_i;
  logic            irq_req_o;
  logic [ID_W-1:0] irq_id_o;
  logic [31:0]     irq_cause_o;
  logic            cfg_we_i;
  logic [1:0]      cfg_addr_i;
  logic [31:0]     cfg_wdata_i;
  logic [31:0]     cfg_rdata_o;
  modport slave (
    input  irq_ack_i, irq_done_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    output irq_req_o, irq_id_o, irq_cause_o, cfg_rdata_o
  );
  modport master (
    output irq_ack_i, irq_done_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
    input  irq_req_o, irq_id_o, irq_cause_o, cfg_rdata_o
  );
endinterface

// File: rtl/irq_arbiter_rr_picker.sv
// rr_picker: round-robin pick of the first request above the last grant, via rotate/encode/unrotate
module rr_picker #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] gnt
);
  logic [W-1:0] start, off;
  logic [N-1:0] rot;
  logic [W:0]   sum;
  always_comb begin
    start = last == W'(N-1) ? '0 : last + W'(1);
    rot = N'({req, req} >> start);
    off = '0;
    for (int i = N-1; i >= 0; i--) off = rot[i] ? W'(i) : off;
    sum = {1'b0, off} + {1'b0, start};
    gnt = sum >= (W+1)'(N) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
  end
  assign found = |req;
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: latches interrupt lines into pending bits and serves one enabled source at a time, round-robin
module irq_arbiter
  import irq_arb_pkg::*;
#(
  parameter int N_SRC = 16,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_src_i,
  irq_arbiter_if.slave     bus
);
  state_e           state;
  logic [N_SRC-1:0] en_q, esel_q, pend_q, src_q;
  logic [N_SRC-1:0] id_oh, set_v, clr_v, pend_n;
  logic [ID_W-1:0]  id_q, last_q, pick_id;
  logic             found, ack;
  logic [31:0]      claim;
  logic             unused_wdata;
  rr_picker #(.N(N_SRC), .W(ID_W)) u_pick (
    .req  (pend_q & en_q),
    .last (last_q),
    .found(found),
    .gnt  (pick_id)
  );
  always_comb begin
    id_oh = N_SRC'(1) << id_q;
    ack = state == REQ && bus.irq_ack_i;
    set_v = ((esel_q & irq_src_i & ~src_q) | (~esel_q & irq_src_i))
          & ~(state != IDLE ? id_oh : {N_SRC{1'b0}});
    clr_v = (bus.cfg_we_i && bus.cfg_addr_i == CFG_PENDING ? bus.cfg_wdata_i[N_SRC-1:0] : {N_SRC{1'b0}})
          | (ack ? id_oh : {N_SRC{1'b0}});
    pend_n = (pend_q & ~clr_v) | set_v;
    claim = {state == SERVICE, 31'(id_q)};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      en_q <= '0;
      esel_q <= '0;
      pend_q <= '0;
      src_q <= '0;
      id_q <= '0;
      last_q <= ID_W'(N_SRC-1);
      bus.cfg_rdata_o <= '0;
    end else begin
      src_q <= irq_src_i;
      pend_q <= pend_n;
      if (bus.cfg_we_i && bus.cfg_addr_i == CFG_ENABLE) en_q <= bus.cfg_wdata_i[N_SRC-1:0];
      if (bus.cfg_we_i && bus.cfg_addr_i == CFG_EDGE_SEL) esel_q <= bus.cfg_wdata_i[N_SRC-1:0];
      bus.cfg_rdata_o <= bus.cfg_addr_i == CFG_ENABLE   ? 32'(en_q)
                       : bus.cfg_addr_i == CFG_EDGE_SEL ? 32'(esel_q)
                       : bus.cfg_addr_i == CFG_PENDING  ? 32'(pend_q)
                       : claim;
      case (state)
        IDLE: if (found) begin
          id_q <= pick_id;
          state <= REQ;
        end
        REQ: if (ack) state <= SERVICE;
             else if (!(pend_q[id_q] && en_q[id_q])) state <= IDLE;
        SERVICE: if (bus.irq_done_i) begin
          last_q <= id_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.irq_req_o = state == REQ;
  assign bus.irq_id_o = id_q;
  assign bus.irq_cause_o = IRQ_CAUSE_BASE + 32'(id_q);
  assign unused_wdata = ^bus.cfg_wdata_i[31:N_SRC];
endmodule
